pc_fetch_sequencer: RTL and testbench

//  Parametrised program-counter/fetch sequencer for the processor front end; successor to the fixed 6-bit PC.

---
 rtl/pc_seq_pkg.sv | 22 ++
 rtl/pc_next_calc.sv | 51 +++++
 rtl/pc_fetch_sequencer.sv | 143 ++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter fetch sequencer: FSM states and the
// redirect record held in the pending-redirect register.
package pc_seq_pkg;

    localparam int ADDR_W_DEF = 6;
    // Redirect targets are stored at this width so the struct is usable for any ADDR_W up to it.
    localparam int MAX_ADDR_W = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_STALL,
        S_HALT
    } state_t;

    typedef struct packed {
        logic                  valid;
        logic                  is_jmp;
        logic [MAX_ADDR_W-1:0] target;
    } redirect_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational successor-PC logic: redirect target (with range check) or
// sequential step with wrap at DEPTH.
module pc_next_calc
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DEPTH    = 64,
    parameter int RESET_PC = 0,
    parameter int STEP     = 1
) (
    input  logic [ADDR_W-1:0] pc,
    input  redirect_t         sel,
    output logic [ADDR_W-1:0] next_pc,
    output logic              wrapped,
    output logic              addr_err
);

    localparam logic [ADDR_W:0]   DEPTH_W    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   STEP_W     = (ADDR_W+1)'(STEP);
    localparam logic [ADDR_W-1:0] RESET_PC_A = ADDR_W'(RESET_PC);

    logic [ADDR_W:0]   seq;
    logic [ADDR_W:0]   seq_wrap;
    logic [ADDR_W-1:0] tgt;
    logic              unused_sel_bits;

    assign unused_sel_bits = ^{sel.is_jmp, sel.target};

    always_comb begin
        seq      = {1'b0, pc} + STEP_W;
        seq_wrap = seq - DEPTH_W;
        tgt      = sel.target[ADDR_W-1:0];
        next_pc  = pc;
        wrapped  = 1'b0;
        addr_err = 1'b0;
        if (sel.valid) begin
            if ({1'b0, tgt} >= DEPTH_W) begin
                next_pc  = RESET_PC_A;
                addr_err = 1'b1;
            end else begin
                next_pc = tgt;
            end
        end else if (seq >= DEPTH_W) begin
            next_pc = seq_wrap[ADDR_W-1:0];
            wrapped = 1'b1;
        end else begin
            next_pc = seq[ADDR_W-1:0];
        end
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program-counter fetch sequencer: issues one instruction fetch at a time over
// req/ack, retires one PC per ack, and handles jump/branch/stall/halt.
module pc_fetch_sequencer
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DEPTH    = 64,
    parameter int RESET_PC = 0,
    parameter int STEP     = 1
) (
    input  logic              clk,
    input  logic              clkreset,
    input  logic              stall,
    input  logic              halt,
    input  logic              jmp_valid,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_offset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    output logic [ADDR_W-1:0] pc_out,
    output logic              pc_valid,
    output logic              wrapped,
    output logic              addr_err,
    output logic              halted,
    output state_t            state_dbg
);

    localparam logic [ADDR_W-1:0] RESET_PC_A = ADDR_W'(RESET_PC);

    // Handshake: imem_req is held with a constant imem_addr until the cycle imem_ack
    // is high; that cycle completes the transfer and the PC retires on the next edge.
    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc;
    logic              pc_wrap, pc_err;
    redirect_t         pend, redir_now, sel;
    logic              halt_seen;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] calc_pc;
    logic              calc_wrap, calc_err;

    assign br_target = pc + br_offset;

    always_comb begin
        redir_now = '0;
        if (state != S_HALT && (jmp_valid || br_valid)) begin
            redir_now.valid  = 1'b1;
            redir_now.is_jmp = jmp_valid;
            redir_now.target = MAX_ADDR_W'(jmp_valid ? jmp_target : br_target);
        end
        sel = redir_now.valid ? redir_now : pend;
    end

    pc_next_calc #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC),
        .STEP     (STEP)
    ) u_calc (
        .pc       (pc),
        .sel      (sel),
        .next_pc  (calc_pc),
        .wrapped  (calc_wrap),
        .addr_err (calc_err)
    );

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = S_REQ;
            S_REQ: begin
                if (imem_ack) begin
                    if (halt || halt_seen) state_nx = S_HALT;
                    else if (stall)        state_nx = S_STALL;
                    else                   state_nx = S_REQ;
                end
            end
            S_STALL: begin
                if (halt || halt_seen) state_nx = S_HALT;
                else if (!stall)       state_nx = S_REQ;
            end
            S_HALT:  state_nx = S_HALT;
            default: state_nx = S_IDLE;
        endcase
    end

    // wrapped/addr_err describe how the current pc was reached; they travel with
    // pc and are reported alongside the pc_valid pulse that retires it.
    always_ff @(posedge clk) begin
        if (!clkreset) begin
            state     <= S_IDLE;
            pc        <= RESET_PC_A;
            pc_wrap   <= 1'b0;
            pc_err    <= 1'b0;
            pend      <= '0;
            halt_seen <= 1'b0;
            pc_out    <= RESET_PC_A;
            pc_valid  <= 1'b0;
            wrapped   <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            pc_valid <= 1'b0;
            wrapped  <= 1'b0;
            addr_err <= 1'b0;
            if (state != S_HALT && halt) halt_seen <= 1'b1;
            case (state)
                S_REQ: begin
                    if (imem_ack) begin
                        pc_out   <= pc;
                        pc_valid <= 1'b1;
                        wrapped  <= pc_wrap;
                        addr_err <= pc_err;
                        pc       <= calc_pc;
                        pc_wrap  <= calc_wrap;
                        pc_err   <= calc_err;
                        pend     <= '0;
                    end else if (redir_now.valid) begin
                        pend <= redir_now;
                    end
                end
                S_STALL: begin
                    if (redir_now.valid) begin
                        pc      <= calc_pc;
                        pc_wrap <= 1'b0;
                        pc_err  <= calc_err;
                    end
                end
                S_IDLE: begin
                    if (redir_now.valid) pend <= redir_now;
                end
                default: ;
            endcase
        end
    end

    assign imem_req  = (state == S_REQ);
    assign imem_addr = pc;
    assign halted    = (state == S_HALT);
    assign state_dbg = state;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: DEPTH=64 and DEPTH=48 instances
// share stimulus; retirements of the DEPTH=64 instance go through a scoreboard.
module tb_pc_fetch_sequencer;
    import pc_seq_pkg::*;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          clkreset = 1'b0;
    logic          stall = 1'b0, halt = 1'b0;
    logic          jmp_valid = 1'b0, br_valid = 1'b0, imem_ack = 1'b0;
    logic [AW-1:0] jmp_target = '0, br_offset = '0;

    logic          req64, pcv64, wr64, err64, halted64;
    logic [AW-1:0] addr64, pc_out64;
    state_t        st64;
    logic          req48, pcv48, wr48, err48, halted48;
    logic [AW-1:0] addr48, pc_out48;
    state_t        st48;

    pc_fetch_sequencer #(.ADDR_W(AW), .DEPTH(64), .RESET_PC(0), .STEP(1)) u_dut64 (
        .clk(clk), .clkreset(clkreset), .stall(stall), .halt(halt),
        .jmp_valid(jmp_valid), .jmp_target(jmp_target),
        .br_valid(br_valid), .br_offset(br_offset),
        .imem_req(req64), .imem_addr(addr64), .imem_ack(imem_ack),
        .pc_out(pc_out64), .pc_valid(pcv64), .wrapped(wr64), .addr_err(err64),
        .halted(halted64), .state_dbg(st64)
    );

    pc_fetch_sequencer #(.ADDR_W(AW), .DEPTH(48), .RESET_PC(0), .STEP(1)) u_dut48 (
        .clk(clk), .clkreset(clkreset), .stall(stall), .halt(halt),
        .jmp_valid(jmp_valid), .jmp_target(jmp_target),
        .br_valid(br_valid), .br_offset(br_offset),
        .imem_req(req48), .imem_addr(addr48), .imem_ack(imem_ack),
        .pc_out(pc_out48), .pc_valid(pcv48), .wrapped(wr48), .addr_err(err48),
        .halted(halted48), .state_dbg(st48)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected TB_RESULT before 100000");
        $fatal(1, "watchdog expired");
    end

    int checks = 0;
    int failures = 0;
    logic [AW+1:0] exp_q[$];
    logic [AW+1:0] sb_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] pc, input logic wr, input logic err);
        exp_q.push_back({err, wr, pc});
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            step();
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        clkreset = 1'b0;
        stall = 1'b0; halt = 1'b0; jmp_valid = 1'b0; br_valid = 1'b0; imem_ack = 1'b0;
        jmp_target = '0; br_offset = '0;
        step();
        step();
        exp_q.delete();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req"},      req64,    0);
        check({tag, "_addr"},     addr64,   0);
        check({tag, "_pc_out"},   pc_out64, 0);
        check({tag, "_pc_valid"}, pcv64,    0);
        check({tag, "_wrapped"},  wr64,     0);
        check({tag, "_addr_err"}, err64,    0);
        check({tag, "_halted"},   halted64, 0);
        check({tag, "_state"},    st64,     S_IDLE);
        check({tag, "_req48"},    req48,    0);
        check({tag, "_halted48"}, halted48, 0);
    endtask

    // scoreboard: every pc_valid of the DEPTH=64 instance pops one expectation
    always @(negedge clk) begin
        if (pcv64) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got pc_out %0d expected no retirement", pc_out64);
            end else begin
                sb_e = exp_q.pop_front();
                check("sb_retire{err,wrap,pc}", {err64, wr64, pc_out64}, sb_e);
            end
        end
    end

    typedef struct {
        logic [AW-1:0] start;
        logic [AW-1:0] off;
        logic [AW-1:0] a64;
        logic          e64;
        logic [AW-1:0] a48;
        logic          e48;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int cnt;

        vecs[0] = '{6'd1,  6'h3E, 6'd63, 1'b0, 6'd0,  1'b1};
        vecs[1] = '{6'd10, 6'd5,  6'd15, 1'b0, 6'd15, 1'b0};
        vecs[2] = '{6'd40, 6'd10, 6'd50, 1'b0, 6'd0,  1'b1};
        vecs[3] = '{6'd0,  6'h3F, 6'd63, 1'b0, 6'd0,  1'b1};
        vecs[4] = '{6'd47, 6'd1,  6'd48, 1'b0, 6'd0,  1'b1};
        vecs[5] = '{6'd20, 6'd44, 6'd0,  1'b0, 6'd0,  1'b0};
        vecs[6] = '{6'd30, 6'd33, 6'd63, 1'b0, 6'd0,  1'b1};

        // 1: free-running fetch with ack tied high, wrap at 64
        do_reset();
        check_reset("t1_reset");
        for (int i = 0; i < 64; i++) push(AW'(i), 1'b0, 1'b0);
        push(6'd0, 1'b1, 1'b0);
        clkreset = 1'b1;
        imem_ack = 1'b1;
        step();
        cnt = 0;
        for (int i = 0; i < 65; i++) begin
            if (!req64) cnt++;
            step();
        end
        check("t1_req_low_cycles", cnt, 0);
        imem_ack = 1'b0;
        drain("t1_drain");

        // 2: ack delayed three cycles at pc=5
        do_reset();
        clkreset = 1'b1;
        imem_ack = 1'b1;
        step();
        for (int i = 0; i < 6; i++) push(AW'(i), 1'b0, 1'b0);
        repeat (5) step();
        imem_ack = 1'b0;
        cnt = 0;
        if (req64 && addr64 == 6'd5) cnt++;
        repeat (3) begin
            step();
            if (req64 && addr64 == 6'd5) cnt++;
        end
        check("t2_req_held_at_5", cnt, 4);
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        check("t2_next_addr", addr64, 6);
        step();
        check("t2_req_after", req64, 1);
        drain("t2_drain");

        // 3: jmp+br captured while fetch of 4 is outstanding, then bypassed branch
        do_reset();
        clkreset = 1'b1;
        imem_ack = 1'b1;
        step();
        for (int i = 0; i < 4; i++) push(AW'(i), 1'b0, 1'b0);
        repeat (4) step();
        imem_ack = 1'b0;
        jmp_valid = 1'b1; jmp_target = 6'd10;
        br_valid = 1'b1;  br_offset = 6'd3;
        step();
        jmp_valid = 1'b0; br_valid = 1'b0;
        check("t3_addr_held", addr64, 4);
        check("t3_req_held", req64, 1);
        imem_ack = 1'b1;
        push(6'd4, 1'b0, 1'b0);
        step();
        check("t3_jmp_wins", addr64, 10);
        push(6'd10, 1'b0, 1'b0);
        br_valid = 1'b1; br_offset = 6'd5;
        step();
        br_valid = 1'b0; imem_ack = 1'b0;
        check("t3_br_bypass", addr64, 15);
        drain("t3_drain");

        // 4: branch table on both depths
        foreach (vecs[i]) begin
            do_reset();
            clkreset = 1'b1;
            step();
            imem_ack = 1'b1;
            jmp_valid = 1'b1; jmp_target = vecs[i].start;
            push(6'd0, 1'b0, 1'b0);
            step();
            jmp_valid = 1'b0; imem_ack = 1'b0;
            br_valid = 1'b1; br_offset = vecs[i].off;
            step();
            br_valid = 1'b0; imem_ack = 1'b1;
            push(vecs[i].start, 1'b0, 1'b0);
            step();
            check($sformatf("t4_v%0d_addr64", i), addr64, vecs[i].a64);
            check($sformatf("t4_v%0d_addr48", i), addr48, vecs[i].a48);
            push(vecs[i].a64, 1'b0, vecs[i].e64);
            step();
            imem_ack = 1'b0;
            check($sformatf("t4_v%0d_{vld,err,pc}48", i), {pcv48, err48, pc_out48},
                  {1'b1, vecs[i].e48, vecs[i].a48});
            drain($sformatf("t4_v%0d_drain", i));
        end

        // 5: stall around the ack of pc=7, then halt during an outstanding fetch
        do_reset();
        clkreset = 1'b1;
        imem_ack = 1'b1;
        step();
        for (int i = 0; i < 7; i++) push(AW'(i), 1'b0, 1'b0);
        repeat (7) step();
        imem_ack = 1'b0;
        stall = 1'b1;
        step();
        check("t5_stall_keeps_req", {req64, addr64}, {1'b1, 6'd7});
        imem_ack = 1'b1;
        push(6'd7, 1'b0, 1'b0);
        step();
        imem_ack = 1'b0;
        cnt = 0;
        if (!req64) cnt++;
        repeat (3) begin
            step();
            if (!req64) cnt++;
        end
        check("t5_req_low_in_stall", cnt, 4);
        stall = 1'b0;
        step();
        check("t5_resume", {req64, addr64}, {1'b1, 6'd8});
        halt = 1'b1;
        step();
        halt = 1'b0;
        check("t5_halt_pending", {req64, halted64, addr64}, {1'b1, 1'b0, 6'd8});
        imem_ack = 1'b1;
        push(6'd8, 1'b0, 1'b0);
        step();
        check("t5_halted", {halted64, req64}, {1'b1, 1'b0});
        jmp_valid = 1'b1; jmp_target = 6'd20;
        cnt = 0;
        repeat (4) begin
            step();
            if (!req64 && halted64) cnt++;
        end
        check("t5_halt_sticky", cnt, 4);
        jmp_valid = 1'b0; imem_ack = 1'b0;
        drain("t5_drain");

        // 6: reset while a request is outstanding
        do_reset();
        check("t6_reset_clears_halt", halted64, 0);
        clkreset = 1'b1;
        imem_ack = 1'b1;
        step();
        for (int i = 0; i < 3; i++) push(AW'(i), 1'b0, 1'b0);
        repeat (3) step();
        imem_ack = 1'b0;
        step();
        check("t6_outstanding", {req64, addr64}, {1'b1, 6'd3});
        check("t6_pre_reset_queue", exp_q.size(), 0);
        clkreset = 1'b0;
        step();
        check_reset("t6_reset");
        clkreset = 1'b1;
        imem_ack = 1'b1;
        push(6'd0, 1'b0, 1'b0);
        push(6'd1, 1'b0, 1'b0);
        step();
        check("t6_restart", {req64, addr64}, {1'b1, 6'd0});
        step();
        step();
        imem_ack = 1'b0;
        drain("t6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
